// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types, window constants and signature step for the MMIO store buffer
package mmio_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    localparam logic [31:0] MMIO_BASE = 32'h0000_0060;
    localparam logic [31:0] MMIO_MASK = 32'hFFFF_FFF8;

    // Shift-left with feedback from taps 31, 30, 29 and 9 after folding in the store.
    function automatic logic [31:0] sig_step(input logic [31:0] sig,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
        logic [31:0] t;
        t = sig ^ addr ^ data;
        return {t[30:0], t[9] ^ t[29] ^ t[30] ^ t[31]};
    endfunction

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - power-of-two FIFO of captured stores with extra-bit pointers
module store_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  store_t                     wr_entry,
    input  logic                       pop,
    output store_t                     rd_entry,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] diff;
    store_t        mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign diff    = wptr - rptr;
    assign count   = CW'(diff);

    // Head reads as zero when empty so the outputs never expose stale slots.
    assign rd_entry = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/mmio_store_buffer.sv
// rtl/mmio_store_buffer.sv - captures MMIO-window stores into a FIFO with status and rolling signature
module mmio_store_buffer
    import mmio_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] WIN_BASE = MMIO_BASE,
    parameter logic [31:0] WIN_MASK = MMIO_MASK
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_write,
    input  logic [31:0]                data_adr,
    input  logic [31:0]                write_data,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       misaligned,
    output logic [15:0]                drop_cnt,
    output logic [31:0]                signature
);

    logic   hit;
    logic   aligned;
    logic   pop;
    logic   accept;
    logic   drop;
    logic   full;
    logic   empty;
    store_t head;

    assign hit       = mem_write && ((data_adr & WIN_MASK) == WIN_BASE);
    assign aligned   = (data_adr[1:0] == 2'b00);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign accept    = hit && aligned && (!full || pop);
    assign drop      = hit && aligned && full && !pop;
    assign out_addr  = head.addr;
    assign out_data  = head.data;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .wr_entry ('{addr: data_adr, data: write_data}),
        .pop      (pop),
        .rd_entry (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // clear outranks same-cycle drop/misalign/accept updates; the push itself still goes ahead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            misaligned <= 1'b0;
            drop_cnt   <= '0;
            signature  <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            misaligned <= 1'b0;
            drop_cnt   <= '0;
            signature  <= '0;
        end else begin
            if (hit && !aligned) misaligned <= 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            if (accept) signature <= sig_step(signature, data_adr, write_data);
        end
    end

endmodule

// File: tb/tb_mmio_store_buffer.sv
// tb/tb_mmio_store_buffer.sv - directed self-checking bench for mmio_store_buffer
module tb_mmio_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic        misaligned;
    logic [15:0] drop_cnt;
    logic [31:0] signature;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_sig;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mmio_store_buffer #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_adr   (data_adr),
        .write_data (write_data),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .count      (count),
        .overflow   (overflow),
        .misaligned (misaligned),
        .drop_cnt   (drop_cnt),
        .signature  (signature)
    );

    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] t;
        logic        fb;
        t  = s ^ a ^ d;
        fb = t[9] ^ t[29] ^ t[30] ^ t[31];
        return (t << 1) | {31'd0, fb};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write  = 1'b1;
        data_adr   = a;
        write_data = d;
        cycle();
        mem_write  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
        clear = 1'b0; out_ready = 1'b0;
        model_sig = '0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            n_fail++; $display("FAIL reset_fifo: out_valid=%b count=%0d required 0/0", out_valid, count);
        end
        n_checks++;
        if (out_addr !== 32'd0 || out_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_head: addr=%h data=%h required 0/0", out_addr, out_data);
        end
        n_checks++;
        if (overflow !== 1'b0 || misaligned !== 1'b0 || drop_cnt !== 16'd0 || signature !== 32'd0) begin
            n_fail++; $display("FAIL reset_status: ovf=%b mis=%b drops=%0d sig=%h required all 0",
                               overflow, misaligned, drop_cnt, signature);
        end
        #10;
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_single_store();
        mem_write = 1'b1; data_adr = 32'd100; write_data = 32'd25;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL no_bypass: out_valid=%b required 0", out_valid);
        end
        cycle();
        mem_write = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'd100 || out_data !== 32'd25 || count !== 4'd1) begin
            n_fail++; $display("FAIL single_store: valid=%b addr=%0d data=%0d count=%0d required 1/100/25/1",
                               out_valid, out_addr, out_data, count);
        end
        n_checks++;
        if (signature !== 32'h0000_00FA) begin
            n_fail++; $display("FAIL single_sig: got %h required 000000fa", signature);
        end
        model_sig = 32'h0000_00FA;
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            n_fail++; $display("FAIL single_pop: valid=%b count=%0d required 0/0", out_valid, count);
        end
        // out_ready while empty must be harmless
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_pop: count=%0d valid=%b required 0/0", count, out_valid);
        end
    endtask

    task automatic test_window();
        store(32'd96, 32'hAAAA_0001);
        model_sig = ref_step(model_sig, 32'd96, 32'hAAAA_0001);
        store(32'd104, 32'hBBBB_0002);
        store(32'd0, 32'hCCCC_0003);
        n_checks++;
        if (count !== 4'd1 || out_addr !== 32'd96 || out_data !== 32'hAAAA_0001) begin
            n_fail++; $display("FAIL window_capture: count=%0d addr=%0d data=%h required 1/96/aaaa0001",
                               count, out_addr, out_data);
        end
        n_checks++;
        if (overflow !== 1'b0 || misaligned !== 1'b0 || signature !== model_sig) begin
            n_fail++; $display("FAIL window_ignore: ovf=%b mis=%b sig=%h required 0/0/%h",
                               overflow, misaligned, signature, model_sig);
        end
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            store((i % 2) ? 32'd100 : 32'd96, 32'h100 + i);
            if (i < 8) model_sig = ref_step(model_sig, (i % 2) ? 32'd100 : 32'd96, 32'h100 + i);
        end
        n_checks++;
        if (count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL overflow_state: count=%0d ovf=%b drops=%0d required 8/1/1",
                               count, overflow, drop_cnt);
        end
        n_checks++;
        if (signature !== model_sig) begin
            n_fail++; $display("FAIL overflow_sig: got %h required %h", signature, model_sig);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== ((i % 2) ? 32'd100 : 32'd96) || out_data !== 32'h100 + i) begin
                n_fail++; $display("FAIL overflow_drain[%0d]: valid=%b addr=%0d data=%h required 1/%0d/%h",
                                   i, out_valid, out_addr, out_data, (i % 2) ? 100 : 96, 32'h100 + i);
            end
            out_ready = 1'b1; cycle(); out_ready = 1'b0;
        end
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL overflow_empty: count=%0d valid=%b required 0/0", count, out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        clear = 1'b1; cycle(); clear = 1'b0;
        model_sig = '0;
        n_checks++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0 || signature !== 32'd0) begin
            n_fail++; $display("FAIL clear_overflow: ovf=%b drops=%0d sig=%h required 0/0/0",
                               overflow, drop_cnt, signature);
        end
        for (int i = 0; i < 8; i++) begin
            store(32'd96, 32'h200 + i);
            model_sig = ref_step(model_sig, 32'd96, 32'h200 + i);
        end
        mem_write = 1'b1; data_adr = 32'd100; write_data = 32'h2FF; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_data !== 32'h200 || count !== 4'd8) begin
            n_fail++; $display("FAIL full_head: data=%h count=%0d required 200/8", out_data, count);
        end
        cycle();
        mem_write = 1'b0; out_ready = 1'b0;
        model_sig = ref_step(model_sig, 32'd100, 32'h2FF);
        n_checks++;
        if (count !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL full_push_pop: count=%0d ovf=%b drops=%0d required 8/0/0",
                               count, overflow, drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_data !== ((i < 7) ? 32'h201 + i : 32'h2FF)) begin
                n_fail++; $display("FAIL full_drain[%0d]: data=%h required %h",
                                   i, out_data, (i < 7) ? 32'h201 + i : 32'h2FF);
            end
            out_ready = 1'b1; cycle(); out_ready = 1'b0;
        end
        n_checks++;
        if (signature !== model_sig || count !== 4'd0) begin
            n_fail++; $display("FAIL full_sig: sig=%h count=%0d required %h/0", signature, count, model_sig);
        end
    endtask

    task automatic test_misaligned();
        store(32'd97, 32'h1234_5678);
        n_checks++;
        if (misaligned !== 1'b1 || count !== 4'd0 || signature !== model_sig || overflow !== 1'b0) begin
            n_fail++; $display("FAIL misaligned: mis=%b count=%0d sig=%h ovf=%b required 1/0/%h/0",
                               misaligned, count, signature, overflow, model_sig);
        end
        clear = 1'b1; mem_write = 1'b1; data_adr = 32'd96; write_data = 32'h55;
        cycle();
        clear = 1'b0; mem_write = 1'b0;
        model_sig = '0;
        n_checks++;
        if (misaligned !== 1'b0 || signature !== 32'd0 || count !== 4'd1 || out_data !== 32'h55) begin
            n_fail++; $display("FAIL clear_with_push: mis=%b sig=%h count=%0d data=%h required 0/0/1/55",
                               misaligned, signature, count, out_data);
        end
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            store(32'd96, 32'h300 + i);
            model_sig = ref_step(model_sig, 32'd96, 32'h300 + i);
            exp_q.push_back(32'h300 + i);
        end
        for (int k = 0; k < 20; k++) begin
            mem_write = 1'b1; data_adr = 32'd100; write_data = 32'h310 + k; out_ready = 1'b1;
            #1;
            n_checks++;
            if (out_data !== exp_q[0]) begin
                n_fail++; $display("FAIL b2b_order[%0d]: data=%h required %h", k, out_data, exp_q[0]);
            end
            cycle();
            void'(exp_q.pop_front());
            exp_q.push_back(32'h310 + k);
            model_sig = ref_step(model_sig, 32'd100, 32'h310 + k);
            n_checks++;
            if (count !== 4'd3) begin
                n_fail++; $display("FAIL b2b_count[%0d]: count=%0d required 3", k, count);
            end
        end
        mem_write = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (signature !== model_sig) begin
            n_fail++; $display("FAIL b2b_sig: got %h required %h", signature, model_sig);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || signature !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: valid=%b count=%0d sig=%h required 0/0/0",
                               out_valid, count, signature);
        end
        cycle();
        reset = 1'b1;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || out_data !== 32'd0) begin
            n_fail++; $display("FAIL post_reset: valid=%b count=%0d data=%h required 0/0/0",
                               out_valid, count, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_window();
        test_overflow();
        test_full_push_pop();
        test_misaligned();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_store_buffer.md
Name: mmio_store_buffer

Overview:
- Consumes the processor/memory store bus (MemWrite, DataAdr, WriteData) directly downstream of the multicycle core top level.
- Captures every store that hits a memory-mapped I/O window into a FIFO, drained by a valid/ready consumer (e.g. a debug UART or a bench scoreboard).
- Keeps a rolling 32-bit signature of accepted stores, plus overflow/error status, so the system can be checked without waveform inspection.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- WIN_BASE, 32'h0000_0060, MMIO window base address.
- WIN_MASK, 32'hFFFF_FFF8, an address hits the window when (DataAdr & WIN_MASK) == WIN_BASE. With the defaults the window is 96..103.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- mem_write  in  1  store strobe from the core, asserted for exactly one cycle per store.
- data_adr  in  32  store address.
- write_data  in  32  store data.
- clear  in  1  synchronous clear of overflow, misaligned, drop_cnt and signature. FIFO contents are untouched.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry when out_valid && out_ready.
- out_addr  out  32  head entry address.
- out_data  out  32  head entry data.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a window hit was dropped because the FIFO was full.
- misaligned  out  1  sticky: a window hit had data_adr[1:0] != 0.
- drop_cnt  out  16  saturating count of dropped hits (saturates at 16'hFFFF).
- signature  out  32  rolling signature of accepted stores.

Behaviour:
- Reset (reset==0, asynchronous): FIFO empty, out_valid=0, out_addr=out_data=0, count=0, overflow=0, misaligned=0, drop_cnt=0, signature=0.
- hit = mem_write && ((data_adr & WIN_MASK)==WIN_BASE). Stores outside the window are ignored entirely.
- Hit with data_adr[1:0] != 0: not pushed, misaligned<=1, signature unchanged.
- Aligned hit is accepted when count<DEPTH, or when count==DEPTH with a pop in the same cycle (out_valid && out_ready).
- Accepted hit: {data_adr, write_data} is written at the tail, and signature updates on the same edge:
  - t = sig ^ data_adr ^ write_data;
  - sig <= {t[30:0], t[9]^t[29]^t[30]^t[31]}.
- Aligned hit that is not accepted: dropped, overflow<=1, drop_cnt increments (saturating), signature unchanged.
- Latency: a store accepted at edge N is visible on out_* after edge N when the FIFO was empty. There is no combinational bypass.
- Outputs out_addr/out_data are combinational reads of the head slot. They are stable while out_valid && !out_ready.
- Pop: out_valid && out_ready at a rising edge advances the head.
- Push and pop in the same cycle: count unchanged, including at count==DEPTH and count==1.
- Read/write pointers are $clog2(DEPTH)+1 bits. Wrap-around is by natural overflow. Full means MSBs differ with equal LSBs; empty means the pointers are equal.
- clear and an event in the same cycle: clear wins for status, and the signature becomes 0; the push itself still occurs.
- Reset mid-stream discards all buffered entries; no partial entry survives.
- out_ready while empty has no effect.

Decomposition:
- Package mmio_pkg:
  - typedef struct packed {logic [31:0] addr; logic [31:0] data;} store_t;
  - constants MMIO_BASE=32'h60, MMIO_MASK=32'hFFFF_FFF8;
  - function sig_step(sig, addr, data) implementing the update above, shared with the bench model.
- One sub-module: store_fifo (parameter DEPTH, store_t payload, push/pop/full/empty/count). The top level holds the window decode, flags, counter and signature.

Test Plan:
- Store 25 to 100 after reset (reset low 22 ns, then high) -> out_valid rises one cycle later with out_addr=100, out_data=25, count=1. Signature equals sig_step(0,100,25).
- Stores to 96, 104 and 0 -> only 96 captured, count=1. Stores to 104 and 0 are ignored with no flags set.
- Nine aligned hits with out_ready=0, DEPTH=8 -> count=8, ninth dropped, overflow=1, drop_cnt=1. The first eight drain in order with out_ready=1.
- FIFO full, hit and out_ready=1 in the same cycle -> new entry accepted, count stays 8, overflow stays 0.
- Store to 97 -> misaligned=1, count unchanged, signature unchanged. Then pulse clear -> misaligned=0, signature=0.
- 20 back-to-back push/pop pairs with DEPTH=8 (pointer wrap) -> data order preserved, count stays constant. Assert reset mid-stream -> out_valid=0 and count=0 immediately (asynchronously).
